// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths, typedefs and helpers
package rf_pkg;
    localparam int DATA_W = 20;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W:0]   reg_cnt_t;

    function automatic reg_cnt_t popcount(input logic [NREG-1:0] v);
        reg_cnt_t c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + reg_cnt_t'(v[i]);
        end
        return c;
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register load-pending bits, population count and sticky error
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  reg_addr_t       wr_addr,
    input  logic            pend_set,
    input  reg_addr_t       pend_addr,
    output logic [NREG-1:0] pending,
    output reg_cnt_t        pend_cnt,
    output logic            pend_err
);
    logic [NREG-1:0] pending_q, pending_d;
    reg_cnt_t        cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            wr_hits_pend;

    assign wr_hits_pend = wr_en && (wr_addr == pend_addr);

    always_comb begin
        pending_d = pending_q;
        // Clear first so a same-address set (the younger load) wins.
        if (wr_en) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (pend_set) begin
            pending_d[pend_addr] = 1'b1;
        end
        cnt_d = popcount(pending_d);
        err_d = err_q | (pend_set & pending_q[pend_addr] & ~wr_hits_pend);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign pending  = pending_q;
    assign pend_cnt = cnt_q;
    assign pend_err = err_q;
endmodule

// File: rtl/register_file_core.sv
// rtl/register_file_core.sv - register storage with write bypass and load-pending stall
module register_file_core
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              rd_used1,
    input  logic              rd_used2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              stall,
    output logic              pend_err,
    output logic [ADDR_W:0]   pend_cnt
);
    reg_data_t       regs_q [NREG];
    reg_data_t       regs_d [NREG];
    logic [NREG-1:0] pending;
    logic            byp1, byp2;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .pending   (pending),
        .pend_cnt  (pend_cnt),
        .pend_err  (pend_err)
    );

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A same-cycle write both supplies the operand and retires the pending load.
    always_comb begin
        byp1     = wr_en && (wr_addr == rd_addr1);
        byp2     = wr_en && (wr_addr == rd_addr2);
        rd_data1 = byp1 ? wr_data : regs_q[rd_addr1];
        rd_data2 = byp2 ? wr_data : regs_q[rd_addr2];
        stall    = (rd_used1 & pending[rd_addr1] & ~byp1)
                 | (rd_used2 & pending[rd_addr2] & ~byp2);
    end
endmodule

// File: tb/tb_register_file_core.sv
// tb/tb_register_file_core.sv - randomized model-checked bench for register_file_core
module tb_register_file_core;
    logic        clk;
    logic        rst;
    logic [3:0]  rd_addr1, rd_addr2;
    logic        rd_used1, rd_used2;
    logic [19:0] rd_data1, rd_data2;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic        pend_set;
    logic [3:0]  pend_addr;
    logic        stall, pend_err;
    logic [4:0]  pend_cnt;

    int checks = 0;
    int errors = 0;

    bit [19:0] m_reg [16];
    bit        m_pend [16];
    bit        m_err;

    register_file_core dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_used1(rd_used1), .rd_used2(rd_used2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .stall(stall), .pend_err(pend_err), .pend_cnt(pend_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: registers, pending flags and sticky error updated from
    // the rules at each clock edge; reset clears everything at once.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            if (pend_set && m_pend[pend_addr] && !(wr_en && wr_addr == pend_addr))
                m_err = 1'b1;
            if (wr_en) begin
                m_reg[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (pend_set)
                m_pend[pend_addr] = 1'b1;
        end
    end

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic logic [19:0] model_rd(input logic [3:0] a);
        if (wr_en && wr_addr == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic model_stall();
        logic s1, s2;
        s1 = rd_used1 && m_pend[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
        s2 = rd_used2 && m_pend[rd_addr2] && !(wr_en && wr_addr == rd_addr2);
        return s1 || s2;
    endfunction

    always @(negedge clk) begin
        chk("rd_data1", 32'(rd_data1), 32'(model_rd(rd_addr1)));
        chk("rd_data2", 32'(rd_data2), 32'(model_rd(rd_addr2)));
        chk("stall",    32'(stall),    32'(model_stall()));
        chk("pend_cnt", 32'(pend_cnt), 32'(model_cnt()));
        chk("pend_err", 32'(pend_err), 32'(m_err));
    end

    task automatic drive(input logic we, input logic [3:0] wa, input logic [19:0] wd,
                         input logic ps, input logic [3:0] pa,
                         input logic [3:0] a1, input logic u1,
                         input logic [3:0] a2, input logic u2);
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        pend_set = ps; pend_addr = pa;
        rd_addr1 = a1; rd_used1 = u1; rd_addr2 = a2; rd_used2 = u2;
        #2;
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0; pend_set = 0; pend_addr = 0;
        rd_addr1 = 0; rd_addr2 = 0; rd_used1 = 0; rd_used2 = 0;

        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 0, 0, 0, 4'(a), 1, 4'(15 - a), 1);
            chk("reset_rd1", 32'(rd_data1), 32'h0);
            chk("reset_rd2", 32'(rd_data2), 32'h0);
            chk("reset_stall", 32'(stall), 32'h0);
            chk("reset_cnt", 32'(pend_cnt), 32'h0);
        end
        @(posedge clk); #1; rst = 1'b0;

        drive(1, 5, 20'hABCDE, 0, 0, 5, 0, 0, 0);
        chk("bypass_rd1", 32'(rd_data1), 32'hABCDE);
        drive(0, 0, 0, 0, 0, 5, 0, 0, 0);
        chk("stored_rd1", 32'(rd_data1), 32'hABCDE);

        drive(0, 0, 0, 1, 3, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 3, 1);
        chk("pend3_stall", 32'(stall), 32'h1);
        chk("pend3_cnt", 32'(pend_cnt), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("pend3_unused", 32'(stall), 32'h0);

        drive(1, 3, 20'h12345, 0, 0, 3, 1, 0, 0);
        chk("wb3_stall", 32'(stall), 32'h0);
        chk("wb3_rd1", 32'(rd_data1), 32'h12345);
        drive(0, 0, 0, 0, 0, 3, 1, 0, 0);
        chk("wb3_cnt", 32'(pend_cnt), 32'h0);

        drive(1, 7, 20'h00F0F, 1, 7, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 7, 1, 0, 0);
        chk("same7_rd1", 32'(rd_data1), 32'h00F0F);
        chk("same7_stall", 32'(stall), 32'h1);
        chk("same7_cnt", 32'(pend_cnt), 32'h1);
        chk("same7_noerr", 32'(pend_err), 32'h0);
        drive(0, 0, 0, 1, 7, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dup7_err", 32'(pend_err), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dup7_sticky", 32'(pend_err), 32'h1);

        drive(1, 1, 20'h11111, 1, 1, 0, 0, 0, 0);
        drive(1, 2, 20'h22222, 1, 2, 0, 0, 0, 0);
        drive(1, 9, 20'h99999, 1, 9, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 9, 1, 7, 1);
        chk("four_cnt", 32'(pend_cnt), 32'h4);
        chk("four_stall", 32'(stall), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_cnt", 32'(pend_cnt), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rd1", 32'(rd_data1), 32'h0);
        chk("rst_rd2", 32'(rd_data2), 32'h0);
        chk("rst_err", 32'(pend_err), 32'h0);
        @(posedge clk); #1; rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk); #1;
                wr_en = 0; pend_set = 0;
                #3 rst = 1'b1;
                @(posedge clk); #2 rst = 1'b0;
            end else begin
                drive($urandom_range(0, 9) < 4, 4'($urandom), 20'($urandom),
                      $urandom_range(0, 9) < 3, 4'($urandom),
                      4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
            end
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file_core.md
Name: register_file_core

Overview:
- Architectural register storage at the consuming end of the register-file input decoder.
- Accepts the decoded destination address and the selected write data (ALU result or RAM load data), plus the two decoded source addresses.
- Returns the two source operands.
- Tracks outstanding loads with a per-register pending scoreboard and raises a stall when an operand is not yet valid.

Parameters:
- DATA_W, 20, register and data width
- ADDR_W, 4, register address width
- NREG, 16, number of registers (2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rd_addr1  input  ADDR_W  source operand 1 address
- rd_addr2  input  ADDR_W  source operand 2 address
- rd_used1  input  1  operand 1 is consumed this cycle (qualifies stall)
- rd_used2  input  1  operand 2 is consumed this cycle (qualifies stall)
- rd_data1  output  DATA_W  operand 1 value
- rd_data2  output  DATA_W  operand 2 value
- wr_en  input  1  write-back strobe
- wr_addr  input  ADDR_W  write-back destination address
- wr_data  input  DATA_W  write-back data
- pend_set  input  1  load issued; mark pend_addr pending
- pend_addr  input  ADDR_W  destination of the issued load
- stall  output  1  a used operand is pending
- pend_err  output  1  sticky: pend_set hit an already-pending register
- pend_cnt  output  ADDR_W+1  number of pending registers

Behaviour:
- Reset (asynchronous, rst=1): all NREG registers clear to 0, all pending bits to 0, pend_err to 0, pend_cnt to 0. rd_data follows the reset contents (0). stall=0.
- Storage: NREG x DATA_W. Write on the rising clk edge when wr_en=1. R0 is a general register, not hardwired.
- Read: combinational, zero latency.
- Bypass: if wr_en=1 and wr_addr==rd_addrN, rd_dataN=wr_data in the same cycle. Otherwise rd_dataN=reg[rd_addrN].
- Scoreboard:
  - Per-register pending bit.
  - pend_set=1 sets pending[pend_addr] at the clock edge.
  - wr_en=1 clears pending[wr_addr] at the clock edge.
  - Same address, same cycle: pend_set wins (the new load is younger than the completing write); the bit stays set and the data is still written.
- stall = OR over N of (rd_usedN & pending[rd_addrN] & ~(wr_en & wr_addr==rd_addrN)).
  - A write arriving in the same cycle satisfies the read via bypass, so it does not stall.
  - stall is purely combinational; it has no registered delay.
- pend_cnt:
  - Registered population count of the pending bits.
  - Increments by 1 on a set of a non-pending bit.
  - Decrements by 1 on a clear of a pending bit.
  - Set and clear on different addresses in the same cycle give a net change of 0.
  - Saturation is impossible (max NREG).
- pend_err:
  - Set when pend_set targets an address already pending and the same cycle's write does not clear it.
  - Sticky until rst. No other effect.
- wr_en to a non-pending register: ordinary ALU write-back, no scoreboard change.
- Reset mid-operation: all pending state is discarded immediately. Load data returning after reset is written as an ordinary write.
- No X propagation: all address decodes are fully specified for every ADDR_W value.

Decomposition:
- Shared package rf_pkg: DATA_W=20, ADDR_W=4, NREG=16, and the reg_addr_t / reg_data_t typedefs, reused by the input decoder and the datapath.
- One sub-module, rf_scoreboard:
  - Contains the pending bits, pend_cnt, and pend_err.
  - Exports the pending vector for the stall logic in the top level.
- The storage array, bypass, and stall OR remain in register_file_core.

Test Plan:
- Reset then read all 16 addresses -> every rd_data=0x00000, stall=0, pend_cnt=0.
- wr_en=1, wr_addr=5, wr_data=0xABCDE with rd_addr1=5 in the same cycle -> rd_data1=0xABCDE (bypass); the next cycle with wr_en=0 still reads 0xABCDE.
- pend_set on addr 3; next cycle rd_addr2=3, rd_used2=1 -> stall=1, pend_cnt=1. Same with rd_used2=0 -> stall=0.
- Pending addr 3; write 0x12345 to addr 3 while rd_addr1=3, rd_used1=1 -> stall=0, rd_data1=0x12345; the next cycle pend_cnt=0.
- Same-cycle pend_set addr 7 and wr_en addr 7 data 0x00F0F -> reg7=0x00F0F, pending[7] stays 1, pend_cnt=1. A second pend_set on addr 7 -> pend_err=1 and it stays 1.
- rst asserted mid-cycle with 4 registers pending and nonzero contents -> immediately pend_cnt=0, stall=0, all reads 0. pend_err cleared.
